// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the op_type / load op_spec encodings, stage bit positions, the
// stage enable/flush patterns used by the sequencer, the sequencer state
// enum and a helper that recognises load instructions.
package pipe_pkg;

  // op_type encodings
  localparam logic [3:0] OP_MATH   = 4'd0;
  localparam logic [3:0] OP_LDST   = 4'd1;
  localparam logic [3:0] OP_BRANCH = 4'd2;
  localparam logic [3:0] OP_JAL    = 4'd3;
  localparam logic [3:0] OP_UPPER  = 4'd4;

  // op_spec encodings of the loads inside OP_LDST; stores sit above SPEC_LHU
  localparam logic [4:0] SPEC_LB  = 5'd0;
  localparam logic [4:0] SPEC_LH  = 5'd1;
  localparam logic [4:0] SPEC_LW  = 5'd2;
  localparam logic [4:0] SPEC_LBU = 5'd3;
  localparam logic [4:0] SPEC_LHU = 5'd4;

  // stage bit positions inside stage_en / stage_flush
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // enable / flush patterns
  localparam logic [4:0] STG_ALL  = 5'b11111;
  localparam logic [4:0] STG_NONE = 5'b00000;
  // everything upstream of writeback is wrong-path after a taken jump
  localparam logic [4:0] FL_JUMP  = STG_ALL & ~(5'b1 << STG_WB);
  // load-use: fetch and decode hold, execute receives a bubble
  localparam logic [4:0] EN_LU    = STG_ALL & ~(5'b1 << STG_IF) & ~(5'b1 << STG_ID);
  localparam logic [4:0] FL_LU    = 5'b1 << STG_EX;

  typedef enum logic [1:0] {
    RST_FL   = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op_type, input logic [4:0] op_spec);
    return (op_type == OP_LDST) && (op_spec <= SPEC_LHU);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of the sequencer's pipeline-facing signals.
// slave  : the sequencer (receives hazard/jump/memory status, drives
//          stage enables, flushes, error flag and perf counters)
// master : the pipeline side (drives status, observes controls)
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       dec_rs1_ind;
  logic [4:0]       dec_rs2_ind;
  logic             dec_rs1_use;
  logic             dec_rs2_use;
  logic [3:0]       ex_op_type;
  logic [4:0]       ex_op_spec;
  logic [4:0]       ex_rd_ind;
  logic             jmp_take;
  logic             mem_req;
  logic             mem_ack;
  logic [4:0]       stage_en;
  logic [4:0]       stage_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  dec_rs1_ind, dec_rs2_ind, dec_rs1_use, dec_rs2_use,
    input  ex_op_type, ex_op_spec, ex_rd_ind,
    input  jmp_take, mem_req, mem_ack,
    output stage_en, stage_flush, mem_err, stall_cnt, flush_cnt
  );

  modport master (
    output dec_rs1_ind, dec_rs2_ind, dec_rs1_use, dec_rs2_use,
    output ex_op_type, ex_op_spec, ex_rd_ind,
    output jmp_take, mem_req, mem_ack,
    input  stage_en, stage_flush, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for performance statistics.
// Ports: clk, clear (synchronous, highest priority), inc (count one event),
//        count (current value, sticks at all-ones).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer of the five-stage pipeline.
// Ports: clk, rst_n (synchronous, active-low), bus (pipe_ctrl_if.slave):
//   decode operand indices/uses, execute op/rd, writeback jmp_take, memory
//   req/ack in; per-stage enable/flush, sticky mem_err and the stall/flush
//   performance counters out.
// Stage controls are combinational from the registered state and the
// current inputs so every decision takes effect in the same cycle.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int RST_FLUSH_CYC = 2,
  parameter int MEM_TIMEOUT   = 64,
  parameter int CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [3:0]          scrub_q, scrub_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_err_q, mem_err_d;

  logic                load_use;
  logic                resolve;
  logic                abort;
  logic                jump_evt;
  logic [4:0]          en;
  logic [4:0]          fl;
  logic                stall_inc;
  logic                flush_inc;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  // rd==x0 never creates a dependency
  assign load_use = is_load(bus.ex_op_type, bus.ex_op_spec) && (bus.ex_rd_ind != 5'd0) &&
                    ((bus.dec_rs1_use && (bus.dec_rs1_ind == bus.ex_rd_ind)) ||
                     (bus.dec_rs2_use && (bus.dec_rs2_ind == bus.ex_rd_ind)));

  always_comb begin
    state_d   = state_q;
    scrub_d   = scrub_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    resolve   = 1'b0;
    abort     = 1'b0;
    jump_evt  = 1'b0;
    en        = STG_ALL;
    fl        = STG_NONE;

    case (state_q)
      RST_FL: begin
        en = STG_ALL;
        fl = STG_ALL;
        if (scrub_q == 4'(RST_FLUSH_CYC - 1)) begin
          state_d = RUN;
        end else begin
          scrub_d = scrub_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          en      = STG_NONE;
          fl      = STG_NONE;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        // An ack on the timeout cycle wins: the access completed normally.
        if (bus.mem_ack) begin
          resolve = 1'b1;
          state_d = RUN;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          resolve   = 1'b1;
          abort     = 1'b1;
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          // jmp_take is held stable by the frozen writeback stage and is
          // acted on once the pipe moves again.
          en     = STG_NONE;
          fl     = STG_NONE;
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = RST_FL;
        en      = STG_NONE;
        fl      = STG_ALL;
      end
    endcase

    if (resolve) begin
      if (bus.jmp_take) begin
        en       = STG_ALL;
        fl       = FL_JUMP;
        jump_evt = 1'b1;
      end else if (load_use) begin
        en = EN_LU;
        fl = FL_LU;
      end else begin
        en = STG_ALL;
        fl = STG_NONE;
      end
      // Aborted access: drop everything the pipe was holding.
      if (abort) begin
        en = STG_ALL;
        fl = FL_JUMP;
      end
    end

    if (!rst_n) begin
      en = STG_NONE;
      fl = STG_ALL;
    end
  end

  assign stall_inc = (state_q != RST_FL) && (en != STG_ALL);
  assign flush_inc = jump_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RST_FL;
      scrub_q   <= 4'd0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scrub_q   <= scrub_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (!rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign bus.stage_en    = en;
  assign bus.stage_flush = fl;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencer for the five-stage pipeline (fetch, decode, execute, memory, writeback). Drives the en/flush pins of every stage's d_register bank. Resolves three events:
- load-use hazards, by stalling and inserting a bubble;
- taken jumps reported by writeback, by flushing the wrong-path stages;
- multi-cycle memory accesses, by freezing the whole pipe.
Also runs a post-reset pipeline scrub and keeps saturating performance counters.

Parameters:
RST_FLUSH_CYC, 2, cycles all stages are flushed after reset release (1..15)
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before abort (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
dec_rs1_ind  in  5  rs1 index of instruction in decode
dec_rs2_ind  in  5  rs2 index of instruction in decode
dec_rs1_use  in  1  decode instruction reads rs1
dec_rs2_use  in  1  decode instruction reads rs2
ex_op_type  in  4  op_type of instruction in execute
ex_op_spec  in  5  op_spec of instruction in execute
ex_rd_ind  in  5  rd index of instruction in execute
jmp_take  in  1  taken jump, from writeback jmp_take_out
mem_req  in  1  memory stage has an outstanding access
mem_ack  in  1  memory access completes this cycle
stage_en  out  5  per-stage register enable, bit0=fetch..bit4=writeback
stage_flush  out  5  per-stage register flush, same indexing
mem_err  out  1  sticky, memory timeout occurred
stall_cnt  out  CNT_W  cycles with any stage_en bit low
flush_cnt  out  CNT_W  taken-jump flush events

Behaviour:
- Reset is synchronous, active-low, sampled on the clk rising edge. While rst_n=0:
  - state<=RST_FL, scrub counter<=0;
  - mem_err, stall_cnt, flush_cnt <= 0;
  - stage_en=0, stage_flush=5'b11111.
- stage_en and stage_flush are combinational from registered state plus current inputs. Zero-latency decisions.
- A load is ex_op_type==4'b0001 with ex_op_spec in {0..4} (lb, lh, lw, lbu, lhu). A store is not a load.
- load_use = load & ex_rd_ind!=0 & ((dec_rs1_use & rs1==rd) | (dec_rs2_use & rs2==rd)).
- RST_FL state:
  - outputs: en=5'b11111, flush=5'b11111;
  - after RST_FL_CYC cycles, go to RUN. These cycles are not counted as stalls.
- RUN state. Priority is highest first; only one case applies per cycle:
  1. mem_req & !mem_ack: en=0, flush=0. Go to MEM_WAIT, wait counter<=1.
  2. jmp_take: en=5'b11111, flush=5'b01111 (fetch through memory). flush_cnt++. The redirect is in effect this cycle, so fetch loads the target.
  3. load_use: en=5'b11100, flush=5'b00100 (bubble into execute, decode/fetch hold).
  4. else: en=5'b11111, flush=0.
- MEM_WAIT state:
  - !mem_ack: en=0, flush=0, wait counter++.
  - mem_ack: behave exactly as RUN cases 2-4 this cycle (a jmp_take or hazard held frozen in the pipe resolves now). Go to RUN.
  - Wait counter reaches MEM_TIMEOUT without ack: mem_err<=1. The cycle is treated as an ack with flush=5'b01111 (abort pipe contents), then RUN.
  - mem_ack and timeout on the same cycle: the ack wins, mem_err unchanged.
- Counters:
  - stall_cnt increments on any RUN/MEM_WAIT cycle where stage_en!=5'b11111.
  - Both counters saturate at all-ones and never wrap.
- mem_err clears only on reset.
- jmp_take during a MEM_WAIT stall cycle is ignored. It is stable because writeback is frozen, and is acted on at the ack cycle.
- Reset asserted mid-MEM_WAIT or mid-RST_FL restarts the scrub unconditionally.

Decomposition:
- Shared package pipe_pkg holds:
  - op_type constants OP_MATH=0, OP_LDST=1, OP_BRANCH=2, OP_JAL=3, OP_UPPER=4;
  - load op_spec constants SPEC_LB..SPEC_LHU;
  - stage index constants STG_IF..STG_WB;
  - the state enum {RST_FL, RUN, MEM_WAIT}.
- One sub-module, sat_counter (parameter W; inc, clear, count), instantiated twice for the perf counters.

Test Plan:
- Reset scrub: hold rst_n=0 3 cycles, release -> flush=5'b11111 for exactly 2 cycles, then 5'b00000 with en=5'b11111. stall_cnt=0.
- Load-use: ex lw (type 1, spec 2, rd=5), dec rs2=5 with rs2_use=1 -> en=5'b11100, flush=5'b00100 for one cycle, stall_cnt=1. Same case with rd=0 -> no stall.
- Jump over hazard: jmp_take=1 with load_use true -> flush=5'b01111, en=5'b11111, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, ack after 4 cycles -> en=0 for 4 cycles, then 5'b11111 on the ack cycle. stall_cnt=4, mem_err=0.
- Jump held across wait: jmp_take=1 during a 3-cycle wait -> no flush until the ack cycle, then flush=5'b01111 once, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, mem_ack never -> mem_err=1 after 4th wait cycle, flush=5'b01111, return to RUN. mem_err stays 1 until rst_n=0.
